rx_iod_lane_align_ctrl: RTL
===========================

# rx_iod_lane_align_ctrl

Parametrised receive-lane training engine that sits between the fabric and a bank of RX IOD lanes running DDRX4 with dynamic delay lines and eye monitors. It drives each lane's delay-line MOVE/DIRECTION/LOAD and EYE_MONITOR_CLEAR_FLAGS. It sweeps the full tap range, finds the longest clean window from EYE_MONITOR_EARLY/LATE, and parks the delay at the window centre. Lanes are trained sequentially, with per-lane status. An optional mode adds continuous drift tracking.

## Interface
Parameters:
- LANES, 2, number of RX lanes (1..16).
- TAP_W, 7, delay tap counter width; TAP_MAX = 2**TAP_W-1.
- SETTLE_CYC, 8, FAB_CLK cycles waited after flag clear before sampling (≥1).
- MIN_EYE, 4, minimum clean-window length in taps for a lane to pass.

Ports:
- FAB_CLK  in  1  sole clock.
- ARST_N  in  1  reset, asynchronous assert, active-low.
- START  in  1  1-cycle pulse, begins training; ignored while BUSY.
- EYE_MONITOR_EARLY  in  LANES  per-lane early flag.
- EYE_MONITOR_LATE  in  LANES  per-lane late flag.
- DELAY_LINE_OUT_OF_RANGE  in  LANES  per-lane range limit.
- DELAY_LINE_MOVE  out  LANES  1-cycle tap move pulse.
- DELAY_LINE_DIRECTION  out  LANES  1 = increment, 0 = decrement.
- DELAY_LINE_LOAD  out  LANES  1-cycle pulse, reloads delay to tap 0.
- EYE_MONITOR_CLEAR_FLAGS  out  LANES  1-cycle flag clear.
- BUSY  out  1  training in progress.
- TRAIN_DONE  out  1  all lanes trained.
- TRAIN_ERR  out  LANES  lane window < MIN_EYE.
- TAP_VAL  out  LANES*TAP_W  current tap per lane, lane n at [n*TAP_W +: TAP_W].

## Operation
- Only the active lane (index `lane`) receives pulses; other bits are 0.
- States: IDLE → LOAD → CLEAR → SETTLE → SAMPLE → (STEP → CLEAR | CENTER) → NEXT → (LOAD | DONE).
- IDLE: on START, clear TRAIN_DONE and TRAIN_ERR, set lane=0, go to LOAD.
- LOAD: pulse LOAD; set tap=0, run_len=0, best_len=0.
- CLEAR: pulse CLEAR_FLAGS.
- SETTLE: wait SETTLE_CYC cycles.
- SAMPLE: good = !(EARLY|LATE|OUT_OF_RANGE).
  - If good: run_len+1 and, when run_len was 0, run_start=tap. Otherwise run_len=0.
  - If new run_len > best_len (strictly), capture best_start/best_len. Ties keep the earlier window.
  - If tap==TAP_MAX or OUT_OF_RANGE, go to CENTER. Otherwise go to STEP.
- STEP: pulse MOVE with DIRECTION=1; tap+1.
- CENTER:
  - If best_len < MIN_EYE: set TRAIN_ERR[lane], pulse LOAD, tap=0.
  - Otherwise target = best_start + (best_len>>1). Issue DIRECTION=0 MOVE pulses, one every 2 cycles (pulse, gap), tap−1 each, until tap==target.
- NEXT: lane+1 to LOAD, or DONE after LANES−1.
- DONE: TRAIN_DONE=1, BUSY=0; START restarts from IDLE behaviour.
- run/best lengths are TAP_W+1 bits wide; tap never wraps.

## Timing
- Reset: all outputs 0, TAP_VAL=0, state IDLE.
- BUSY rises the cycle after START is sampled and falls in the DONE cycle.
- Per-tap cost: 1 (CLEAR) + SETTLE_CYC + 1 (SAMPLE) + 1 (STEP).
- DIRECTION is valid in the same cycle as MOVE and holds its value between pulses.
- ARST_N low mid-sweep: immediate return to reset values. The delay line is reloaded by the next training run.
- START pulse while BUSY: no effect.

## Configuration
- RX_ALIGN_TRACK_EN defined: in DONE, lanes are serviced round-robin. For each lane, pass lanes only:
  - Sequence: CLEAR, SETTLE, SAMPLE.
  - EARLY only and tap<TAP_MAX and !OUT_OF_RANGE: one MOVE with DIRECTION=1, tap+1.
  - LATE only and tap>0: one MOVE with DIRECTION=0, tap−1.
  - Neither or both: no move.
  - TRAIN_DONE stays 1 and BUSY stays 0 throughout tracking.
- Undefined: DONE is static; no pulses are issued after training.

## Test plan
All scenarios use LANES=2, TAP_W=4, SETTLE_CYC=4, MIN_EYE=3.
- Reset: hold ARST_N=0 → all outputs 0, TAP_VAL=0x00; release, no START → outputs unchanged.
- Lane0 clean on taps 5..11, lane1 clean on 0..15 → TAP_VAL[3:0]=8, TAP_VAL[7:4]=8, TRAIN_ERR=0, TRAIN_DONE=1; lane0 receives 7 decrement MOVEs after its sweep.
- Lane0 windows 2..4 and 9..12 → tap 11. Equal windows 1..3 and 8..10 → tap 2 (earlier window wins).
- Lane1 clean only on 6..7 → TRAIN_ERR=2'b10, TAP_VAL[7:4]=0, LOAD pulsed on lane1 in CENTER; lane0 result unaffected.
- Lane0 clean 3..12 with OUT_OF_RANGE asserted at tap 10 → sweep stops at tap 10, window 3..9, final tap 6.
- START during BUSY ignored; ARST_N pulse at tap 7 → outputs 0, next START retrains from tap 0. With RX_ALIGN_TRACK_EN defined and lane0 EARLY held → lane0 tap steps up by 1 per service, stopping at 15.

Source files
------------

// File: rtl/rx_iod_lane_align_ctrl.sv
// rx_iod_lane_align_ctrl
// ----------------------
// Receive-lane training engine for a bank of RX IOD lanes with dynamic delay
// lines and eye monitors. Lanes are trained one after another. For each lane
// the engine sweeps the delay line from tap 0 upwards and samples the eye
// monitor flags at every tap. It records the longest clean window, then
// steps the delay back down to the centre of that window. A lane whose best
// window is shorter than MIN_EYE is flagged in TRAIN_ERR and reloaded to
// tap 0.
//
// Optional feature macro: RX_ALIGN_TRACK_EN. When it is defined, the DONE
// state services the passing lanes round-robin and nudges each one by a
// single tap towards the eye centre, following EARLY/LATE.
//
// Ports:
//   FAB_CLK                  sole clock
//   ARST_N                   asynchronous active-low reset
//   START                    1-cycle pulse that starts training (ignored while BUSY)
//   EYE_MONITOR_EARLY/LATE   per-lane eye monitor flags
//   DELAY_LINE_OUT_OF_RANGE  per-lane delay range limit
//   DELAY_LINE_MOVE          per-lane 1-cycle tap move pulse
//   DELAY_LINE_DIRECTION     per-lane direction (1 = increment); held between pulses
//   DELAY_LINE_LOAD          per-lane 1-cycle reload-to-tap-0 pulse
//   EYE_MONITOR_CLEAR_FLAGS  per-lane 1-cycle flag clear
//   BUSY                     training in progress
//   TRAIN_DONE               all lanes trained
//   TRAIN_ERR                per-lane "window shorter than MIN_EYE"
//   TAP_VAL                  current tap per lane, lane n at [n*TAP_W +: TAP_W]
module rx_iod_lane_align_ctrl #(
    parameter int LANES      = 2,
    parameter int TAP_W      = 7,
    parameter int SETTLE_CYC = 8,
    parameter int MIN_EYE    = 4
) (
    input  logic                   FAB_CLK,
    input  logic                   ARST_N,
    input  logic                   START,
    input  logic [LANES-1:0]       EYE_MONITOR_EARLY,
    input  logic [LANES-1:0]       EYE_MONITOR_LATE,
    input  logic [LANES-1:0]       DELAY_LINE_OUT_OF_RANGE,
    output logic [LANES-1:0]       DELAY_LINE_MOVE,
    output logic [LANES-1:0]       DELAY_LINE_DIRECTION,
    output logic [LANES-1:0]       DELAY_LINE_LOAD,
    output logic [LANES-1:0]       EYE_MONITOR_CLEAR_FLAGS,
    output logic                   BUSY,
    output logic                   TRAIN_DONE,
    output logic [LANES-1:0]       TRAIN_ERR,
    output logic [LANES*TAP_W-1:0] TAP_VAL
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CNT_W  = $clog2(SETTLE_CYC + 1);
    localparam int LEN_W  = TAP_W + 1;
    localparam logic [TAP_W-1:0] TAP_MAX = {TAP_W{1'b1}};

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_CLEAR, S_SETTLE, S_SAMPLE, S_STEP, S_CENTER, S_NEXT,
        S_DONE, S_TCLEAR, S_TSETTLE, S_TSAMPLE, S_TMOVE
    } state_t;

    state_t             state_q, state_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [TAP_W-1:0]   tap_q [LANES];
    logic [TAP_W-1:0]   tap_d [LANES];
    logic [LEN_W-1:0]   run_len_q, run_len_d, best_len_q, best_len_d;
    logic [TAP_W-1:0]   run_start_q, run_start_d, best_start_q, best_start_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic               center_ph_q, center_ph_d;
    logic               done_q, done_d;
    logic [LANES-1:0]   err_q, err_d;

    logic               move_p, load_p, clr_p, busy;
    logic [LANES-1:0]   lane_oh;
    logic [LANE_W-1:0]  lane_nxt;
    logic [TAP_W-1:0]   tap_cur;
    logic               early_cur, late_cur, oor_cur, good;
    logic [LEN_W-1:0]   run_new, target;
    logic               at_target, eye_ok;

    assign lane_oh   = LANES'(1) << lane_q;
    assign lane_nxt  = (lane_q == LANE_W'(LANES - 1)) ? '0 : lane_q + LANE_W'(1);
    assign tap_cur   = tap_q[lane_q];
    assign early_cur = EYE_MONITOR_EARLY[lane_q];
    assign late_cur  = EYE_MONITOR_LATE[lane_q];
    assign oor_cur   = DELAY_LINE_OUT_OF_RANGE[lane_q];
    assign good      = !(early_cur || late_cur || oor_cur);
    assign run_new   = good ? run_len_q + LEN_W'(1) : '0;
    assign target    = {1'b0, best_start_q} + (best_len_q >> 1);
    assign at_target = ({1'b0, tap_cur} == target);
    assign eye_ok    = (best_len_q >= LEN_W'(MIN_EYE));
    assign busy      = (state_q inside {S_LOAD, S_CLEAR, S_SETTLE, S_SAMPLE,
                                        S_STEP, S_CENTER, S_NEXT});

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        tap_d        = tap_q;
        run_len_d    = run_len_q;
        best_len_d   = best_len_q;
        run_start_d  = run_start_q;
        best_start_d = best_start_q;
        cnt_d        = cnt_q;
        dir_d        = dir_q;
        center_ph_d  = center_ph_q;
        done_d       = done_q;
        err_d        = err_q;
        move_p       = 1'b0;
        load_p       = 1'b0;
        clr_p        = 1'b0;

        case (state_q)
            S_LOAD: begin
                load_p        = 1'b1;
                tap_d[lane_q] = '0;
                run_len_d     = '0;
                best_len_d    = '0;
                state_d       = S_CLEAR;
            end
            S_CLEAR: begin
                clr_p   = 1'b1;
                cnt_d   = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) state_d = S_SAMPLE;
                else                                 cnt_d   = cnt_q + CNT_W'(1);
            end
            S_SAMPLE: begin
                run_len_d = run_new;
                if (good && run_len_q == '0) run_start_d = tap_cur;
                // Strict compare: on a tie the earlier window is kept.
                if (run_new > best_len_q) begin
                    best_len_d   = run_new;
                    best_start_d = (run_len_q == '0) ? tap_cur : run_start_q;
                end
                if (tap_cur == TAP_MAX || oor_cur) begin
                    state_d     = S_CENTER;
                    dir_d       = 1'b0;
                    center_ph_d = 1'b0;
                end else begin
                    state_d = S_STEP;
                    dir_d   = 1'b1;
                end
            end
            S_STEP: begin
                move_p        = 1'b1;
                tap_d[lane_q] = tap_cur + TAP_W'(1);
                state_d       = S_CLEAR;
            end
            S_CENTER: begin
                if (!eye_ok) begin
                    err_d[lane_q] = 1'b1;
                    load_p        = 1'b1;
                    tap_d[lane_q] = '0;
                    state_d       = S_NEXT;
                end else if (at_target) begin
                    state_d = S_NEXT;
                end else if (!center_ph_q) begin
                    // Decrement pulses alternate with an idle gap cycle.
                    move_p        = 1'b1;
                    tap_d[lane_q] = tap_cur - TAP_W'(1);
                    center_ph_d   = 1'b1;
                end else begin
                    center_ph_d = 1'b0;
                end
            end
            S_NEXT: begin
                lane_d = lane_nxt;
                if (lane_q == LANE_W'(LANES - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_LOAD;
                end
            end
`ifdef RX_ALIGN_TRACK_EN
            S_DONE: begin
                if (err_q[lane_q]) lane_d  = lane_nxt;
                else               state_d = S_TCLEAR;
            end
            S_TCLEAR: begin
                clr_p   = 1'b1;
                cnt_d   = '0;
                state_d = S_TSETTLE;
            end
            S_TSETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) state_d = S_TSAMPLE;
                else                                 cnt_d   = cnt_q + CNT_W'(1);
            end
            S_TSAMPLE: begin
                if (early_cur && !late_cur && tap_cur != TAP_MAX && !oor_cur) begin
                    dir_d   = 1'b1;
                    state_d = S_TMOVE;
                end else if (late_cur && !early_cur && tap_cur != '0) begin
                    dir_d   = 1'b0;
                    state_d = S_TMOVE;
                end else begin
                    lane_d  = lane_nxt;
                    state_d = S_DONE;
                end
            end
            S_TMOVE: begin
                move_p        = 1'b1;
                tap_d[lane_q] = dir_q ? tap_cur + TAP_W'(1) : tap_cur - TAP_W'(1);
                lane_d        = lane_nxt;
                state_d       = S_DONE;
            end
`else
            S_DONE: state_d = S_DONE;
`endif
            default: state_d = S_IDLE;
        endcase

        // Any non-busy state (idle, done, tracking) accepts a new run.
        if (!busy && START) begin
            state_d = S_LOAD;
            lane_d  = '0;
            done_d  = 1'b0;
            err_d   = '0;
        end
    end

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q      <= S_IDLE;
            lane_q       <= '0;
            for (int i = 0; i < LANES; i++) tap_q[i] <= '0;
            run_len_q    <= '0;
            best_len_q   <= '0;
            run_start_q  <= '0;
            best_start_q <= '0;
            cnt_q        <= '0;
            dir_q        <= 1'b0;
            center_ph_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            tap_q        <= tap_d;
            run_len_q    <= run_len_d;
            best_len_q   <= best_len_d;
            run_start_q  <= run_start_d;
            best_start_q <= best_start_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            center_ph_q  <= center_ph_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign DELAY_LINE_MOVE         = move_p ? lane_oh : '0;
    assign DELAY_LINE_DIRECTION    = dir_q  ? lane_oh : '0;
    assign DELAY_LINE_LOAD         = load_p ? lane_oh : '0;
    assign EYE_MONITOR_CLEAR_FLAGS = clr_p  ? lane_oh : '0;
    assign BUSY                    = busy;
    assign TRAIN_DONE              = done_q;
    assign TRAIN_ERR               = err_q;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_tap_val
            assign TAP_VAL[gi*TAP_W +: TAP_W] = tap_q[gi];
        end
    endgenerate

endmodule
